// File: rtl/bp_pkg.sv
// ============================================================================
// bp_pkg : shared counter types, state encoding and saturating-counter helper
// Rev 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    if (taken)
      return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    else
      return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_bht_if.sv
// ============================================================================
// bp_bht_if : fetch/execute side bundle of the branch history table
// Rev 1.0
// ============================================================================
`default_nettype none

interface bp_bht_if #(
  parameter int IDX_W  = 8,
  parameter int HIST_W = 8
);
  logic              lookup_valid;
  logic [IDX_W-1:0]  addr;
  logic              ready;
  logic              pred_valid;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic [HIST_W-1:0] pred_ghr;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_mispredict;
  logic [HIST_W-1:0] upd_ghr;

  modport master (
    output lookup_valid, addr, upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
    input  ready, pred_valid, pred_taken, pred_idx, pred_ghr
  );

  modport slave (
    input  lookup_valid, addr, upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
    output ready, pred_valid, pred_taken, pred_idx, pred_ghr
  );
endinterface

`default_nettype wire

// File: rtl/bp_ctr_ram.sv
// ============================================================================
// bp_ctr_ram : 2^IDX_W x 2-bit counter store, sync read of counter MSB,
//              read-modify-write port with write-first bypass.  Rev 1.0
// ============================================================================
`default_nettype none

module bp_ctr_ram
  import bp_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic             rd_taken,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic             wload,
  input  ctr_t             wval,
  input  logic             wtaken
);
  localparam int DEPTH = 1 << IDX_W;

  ctr_t mem [DEPTH];
  ctr_t wnew;

  // wload selects a plain store (init sweep) over the saturating step (update)
  always_comb begin
    wnew = wload ? wval : ctr_next(mem[waddr], wtaken);
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wnew;
    if (re)
      rd_taken <= (we && (waddr == raddr)) ? wnew[1] : mem[raddr][1];
  end

endmodule

`default_nettype wire

// File: rtl/bp_bht.sv
// ============================================================================
// bp_bht : 2-bit saturating branch history table, optional gshare indexing,
//          self-initialising sweep after reset.  Rev 1.0
// ============================================================================
`default_nettype none

module bp_bht
  import bp_pkg::*;
#(
  parameter int   IDX_W    = 8,
  parameter int   GSHARE   = 0,
  parameter int   HIST_W   = 8,
  parameter ctr_t CTR_INIT = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  bp_bht_if.slave    bus
);
  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [HIST_W-1:0] ghr, ghr_nxt, ghr_spec, ghr_recov;
  logic [IDX_W-1:0]  lk_idx;
  logic              run, accept, upd_en;
  logic              pv;
  logic [IDX_W-1:0]  pidx;
  logic [HIST_W-1:0] pghr;
  logic              rd_taken;
  logic              pred_taken;

  assign run    = (state == ST_RUN);
  assign accept = run & bus.lookup_valid;
  assign upd_en = run & bus.upd_valid;

  generate
    if (GSHARE != 0) begin : g_gshare
      assign lk_idx = bus.addr ^ IDX_W'(ghr);
    end else begin : g_bimodal
      assign lk_idx = bus.addr;
    end
  endgenerate

  // Init sweep state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_INIT: begin
        ptr_nxt = ptr + IDX_W'(1);
        if (ptr == {IDX_W{1'b1}})
          state_nxt = ST_RUN;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  bp_ctr_ram #(.IDX_W(IDX_W)) u_ram (
    .clk      (clk),
    .re       (accept),
    .raddr    (lk_idx),
    .rd_taken (rd_taken),
    .we       (~run | upd_en),
    .waddr    (run ? bus.upd_idx : ptr),
    .wload    (~run),
    .wval     (CTR_INIT),
    .wtaken   (bus.upd_taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv   <= 1'b0;
      pidx <= '0;
      pghr <= '0;
    end else begin
      pv <= accept;
      if (accept) begin
        pidx <= lk_idx;
        pghr <= ghr;
      end
    end
  end

  assign pred_taken = pv & rd_taken;

  generate
    if (HIST_W == 1) begin : g_hist1
      assign ghr_spec  = pred_taken;
      assign ghr_recov = bus.upd_taken;
    end else begin : g_histn
      assign ghr_spec  = {ghr[HIST_W-2:0], pred_taken};
      assign ghr_recov = {bus.upd_ghr[HIST_W-2:0], bus.upd_taken};
    end
  endgenerate

  // Mispredict recovery overrides the speculative shift of the same cycle
  always_comb begin
    ghr_nxt = ghr;
    if (upd_en && bus.upd_mispredict)
      ghr_nxt = ghr_recov;
    else if (pv)
      ghr_nxt = ghr_spec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ghr <= '0;
    else
      ghr <= (GSHARE != 0) ? ghr_nxt : '0;
  end

  assign bus.ready      = run;
  assign bus.pred_valid = pv;
  assign bus.pred_taken = pred_taken;
  assign bus.pred_idx   = pidx;
  assign bus.pred_ghr   = pghr;

endmodule

`default_nettype wire

// File: tb/tb_bp_bht.sv
// ============================================================================
// tb_bp_bht : scoreboard bench for bimodal (u_dut0) and gshare (u_dut1) tables
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bp_bht;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic       taken;
    logic [7:0] idx;
    logic [7:0] ghr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  bp_bht_if #(.IDX_W(8), .HIST_W(8)) b0 ();
  bp_bht_if #(.IDX_W(8), .HIST_W(8)) b1 ();

  bp_bht #(.IDX_W(8), .GSHARE(0), .HIST_W(8), .CTR_INIT(2'b01)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  bp_bht #(.IDX_W(8), .GSHARE(1), .HIST_W(8), .CTR_INIT(2'b01)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    b0.lookup_valid = 0; b0.addr = 0; b0.upd_valid = 0; b0.upd_idx = 0;
    b0.upd_taken = 0; b0.upd_mispredict = 0; b0.upd_ghr = 0;
    b1.lookup_valid = 0; b1.addr = 0; b1.upd_valid = 0; b1.upd_idx = 0;
    b1.upd_taken = 0; b1.upd_mispredict = 0; b1.upd_ghr = 0;
  endtask

  // Junk traffic that must be ignored while the table initialises
  task automatic set_junk();
    b0.lookup_valid = 1; b0.addr = 8'h05; b0.upd_valid = 1; b0.upd_idx = 8'h05;
    b0.upd_taken = 0; b0.upd_mispredict = 1; b0.upd_ghr = 8'hFF;
    b1.lookup_valid = 1; b1.addr = 8'h05; b1.upd_valid = 1; b1.upd_idx = 8'h05;
    b1.upd_taken = 0; b1.upd_mispredict = 1; b1.upd_ghr = 8'hFF;
  endtask

  task automatic step(input logic [1:0] m, input bit lv, input logic [7:0] a,
                      input bit uv, input logic [7:0] ui, input bit ut,
                      input bit um, input logic [7:0] ug);
    @(posedge clk); #1;
    clear_all();
    if (m[0]) begin
      b0.lookup_valid = lv; b0.addr = a; b0.upd_valid = uv; b0.upd_idx = ui;
      b0.upd_taken = ut; b0.upd_mispredict = um; b0.upd_ghr = ug;
    end
    if (m[1]) begin
      b1.lookup_valid = lv; b1.addr = a; b1.upd_valid = uv; b1.upd_idx = ui;
      b1.upd_taken = ut; b1.upd_mispredict = um; b1.upd_ghr = ug;
    end
  endtask

  task automatic idle();                                          step(2'b00, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic look(input logic [1:0] m, input logic [7:0] a);  step(m, 1, a, 0, 0, 0, 0, 0);     endtask
  task automatic up(input logic [1:0] m, input logic [7:0] i, input bit t); step(m, 0, 0, 1, i, t, 0, 0); endtask

  task automatic push(input int d, input logic t, input logic [7:0] i, input logic [7:0] g);
    exp_t e;
    e.taken = t; e.idx = i; e.ghr = g;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready0"}, 32'(b0.ready), 32'd0);
    check({tag, " ready1"}, 32'(b1.ready), 32'd0);
    check({tag, " pv0"},    32'(b0.pred_valid), 32'd0);
    check({tag, " pv1"},    32'(b1.pred_valid), 32'd0);
    check({tag, " pt0"},    32'(b0.pred_taken), 32'd0);
    check({tag, " pt1"},    32'(b1.pred_taken), 32'd0);
  endtask

  // Scoreboard monitor: pops an expectation each time a prediction appears
  always @(negedge clk) begin
    exp_t e;
    if (b0.pred_valid === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0 unexpected pred: got idx %0h expected none", b0.pred_idx);
      end else begin
        e = q0.pop_front();
        check("dut0 taken", 32'(b0.pred_taken), 32'(e.taken));
        check("dut0 idx",   32'(b0.pred_idx),   32'(e.idx));
        check("dut0 ghr",   32'(b0.pred_ghr),   32'(e.ghr));
      end
    end else if (b0.pred_valid === 1'b0) begin
      check("dut0 taken when idle", 32'(b0.pred_taken), 32'd0);
    end
    if (b1.pred_valid === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected pred: got idx %0h expected none", b1.pred_idx);
      end else begin
        e = q1.pop_front();
        check("dut1 taken", 32'(b1.pred_taken), 32'(e.taken));
        check("dut1 idx",   32'(b1.pred_idx),   32'(e.idx));
        check("dut1 ghr",   32'(b1.pred_ghr),   32'(e.ghr));
      end
    end else if (b1.pred_valid === 1'b0) begin
      check("dut1 taken when idle", 32'(b1.pred_taken), 32'd0);
    end
  end

  initial begin
    clear_all();
    rst_n = 1'b0;
    b0.lookup_valid = 1; b0.addr = 8'h33;
    b1.lookup_valid = 1; b1.addr = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("reset");
    end
    check("reset pidx0", 32'(b0.pred_idx), 32'd0);
    check("reset pghr1", 32'(b1.pred_ghr), 32'd0);

    // First sweep interrupted at ptr=100 with junk traffic present
    rst_n = 1'b1;
    set_junk();
    repeat (100) @(posedge clk);
    #1;
    check_idle("sweep");
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("midreset");
    rst_n = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    check("ready0 at 255", 32'(b0.ready), 32'd0);
    check("ready1 at 255", 32'(b1.ready), 32'd0);
    @(posedge clk); #1;
    check("ready0 at 256", 32'(b0.ready), 32'd1);
    check("ready1 at 256", 32'(b1.ready), 32'd1);
    clear_all();

    // Fresh table: every entry weakly not-taken, history stays zero
    for (int a = 0; a < 256; a++) begin
      look(2'b11, 8'(a));
      push(0, 1'b0, 8'(a), 8'h00);
      push(1, 1'b0, 8'(a), 8'h00);
    end
    idle();

    // Bimodal training and saturation on entry 0x2A
    up(2'b01, 8'h2A, 1); up(2'b01, 8'h2A, 1);
    look(2'b01, 8'h2A); push(0, 1'b1, 8'h2A, 8'h00);
    up(2'b01, 8'h2A, 1); up(2'b01, 8'h2A, 0);
    look(2'b01, 8'h2A); push(0, 1'b1, 8'h2A, 8'h00);
    up(2'b01, 8'h2A, 0);
    look(2'b01, 8'h2A); push(0, 1'b0, 8'h2A, 8'h00);
    up(2'b01, 8'h2A, 0);
    look(2'b01, 8'h2A); push(0, 1'b0, 8'h2A, 8'h00);
    up(2'b01, 8'h2A, 0);
    look(2'b01, 8'h2A); push(0, 1'b0, 8'h2A, 8'h00);
    up(2'b01, 8'h2A, 0); up(2'b01, 8'h2A, 0); up(2'b01, 8'h2A, 0);
    up(2'b01, 8'h2A, 1);
    look(2'b01, 8'h2A); push(0, 1'b0, 8'h2A, 8'h00);

    // Same-cycle update and lookup of entry 5 sees the incremented counter
    step(2'b01, 1, 8'h05, 1, 8'h05, 1, 0, 8'h00); push(0, 1'b1, 8'h05, 8'h00);
    idle();

    // Gshare: train, then predict 0,1,1 to build ghr=0x03
    up(2'b10, 8'h20, 1); up(2'b10, 8'h31, 1); idle();
    look(2'b10, 8'h10); push(1, 1'b0, 8'h10, 8'h00); idle();
    look(2'b10, 8'h20); push(1, 1'b1, 8'h20, 8'h00); idle();
    look(2'b10, 8'h30); push(1, 1'b1, 8'h31, 8'h01); idle();
    look(2'b10, 8'h40); push(1, 1'b0, 8'h43, 8'h03);
    // Recovery to {0x05,1}=0x0B while the prediction above is presented
    step(2'b10, 0, 8'h00, 1, 8'h77, 1, 1, 8'h05);
    look(2'b10, 8'h00); push(1, 1'b0, 8'h0B, 8'h0B); idle();
    look(2'b10, 8'h00); push(1, 1'b0, 8'h16, 8'h16);
    repeat (3) idle();

    check("q0 drained", 32'(q0.size()), 32'd0);
    check("q1 drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
